// File: rtl/cnt_seq_chk.sv
// Receive-side checker for an incrementing counter bus: locks onto the +1 sequence,
// pulses/counts sequence errors and reports loss of lock. Build with
// CNT_SEQ_CHK_ERR_CAPTURE_EN to keep the expected/received values of the first error.
//
// state  | meaning
// IDLE   | disabled; history and run counters cleared
// SEARCH | looking for LOCK_CNT consecutive +1 steps, errors not counted
// LOCKED | sequence tracked, mismatches pulse err and bump err_cnt
module cnt_seq_chk #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [W-1:0]     first_exp,
  output logic [W-1:0]     first_got,
  output logic             cap_valid
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  state_t          state, state_n;
  logic [W-1:0]    din_q, prev, exp_val;
  logic            prev_vld, match, err_ev;
  logic [GW-1:0]   good_cnt, good_n;
  logic [BW-1:0]   bad_cnt, bad_n;

  assign exp_val = prev + W'(1);
  assign match   = prev_vld && (din_q == exp_val);
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      din_q    <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_n;
      din_q    <= din;
      good_cnt <= good_n;
      bad_cnt  <= bad_n;
      if (state != IDLE) begin
        prev     <= din_q;
        prev_vld <= 1'b1;
      end else begin
        prev_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    err_ev  = 1'b0;
    case (state)
      IDLE: begin
        good_n = '0;
        bad_n  = '0;
        if (en) state_n = SEARCH;
      end
      SEARCH: begin
        if (match) begin
          if (good_cnt == GOOD_LAST) begin
            state_n = LOCKED;
            good_n  = '0;
            bad_n   = '0;
          end else begin
            good_n = good_cnt + GW'(1);
          end
        end else if (prev_vld) begin
          good_n = '0;
        end
      end
      LOCKED: begin
        if (match) begin
          bad_n = '0;
        end else if (prev_vld) begin
          err_ev = 1'b1;
          if (bad_cnt == BAD_LAST) begin
            state_n = SEARCH;
            good_n  = '0;
            bad_n   = '0;
          end else begin
            bad_n = bad_cnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Disable wins over everything, including an error seen on the same cycle.
    if (!en) begin
      state_n = IDLE;
      good_n  = '0;
      bad_n   = '0;
      err_ev  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= err_ev;
      if (clr)
        err_cnt <= err_ev ? ERR_W'(1) : '0;
      else if (err_ev && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

`ifdef CNT_SEQ_CHK_ERR_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_exp <= '0;
      first_got <= '0;
      cap_valid <= 1'b0;
    end else if (err_ev && (clr || !cap_valid)) begin
      first_exp <= exp_val;
      first_got <= din_q;
      cap_valid <= 1'b1;
    end else if (clr) begin
      first_exp <= '0;
      first_got <= '0;
      cap_valid <= 1'b0;
    end
  end
`else
  assign first_exp = '0;
  assign first_got = '0;
  assign cap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_seq_chk.sv
// Directed bench for cnt_seq_chk (W=4, LOCK_CNT=8, LOSS_CNT=4, ERR_W=4): lock, wrap,
// glitch, loss/relock, clear, saturation, enable and async reset, plus error capture.
module tb_cnt_seq_chk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] din = 4'd0;
  logic       locked, err, cap_valid;
  logic [3:0] err_cnt, first_exp, first_got;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] s;

`ifdef CNT_SEQ_CHK_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  cnt_seq_chk #(.W(4), .LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt),
    .first_exp(first_exp), .first_got(first_got), .cap_valid(cap_valid)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] v, input logic e, input logic c);
    din = v; en = e; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_cap(input string tag, input logic [3:0] e, input logic [3:0] g);
    chk({tag, "_exp"}, first_exp, CAP ? e : 4'd0);
    chk({tag, "_got"}, first_got, CAP ? g : 4'd0);
    chk({tag, "_vld"}, cap_valid, CAP ? 1 : 0);
  endtask

  initial begin
    #11;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_cap_vld", cap_valid, 0);
    #1 rst_n = 1'b1;

    // lock on 0,1,2,... and run through the 15->0 wrap
    for (int k = 1; k <= 20; k++) begin
      tick(4'(k - 1), 1'b1, 1'b0);
      if (k == 9)  chk("lock_early", locked, 0);
      if (k == 10) chk("lock_on", locked, 1);
    end
    chk("wrap_err", err, 0);
    chk("wrap_cnt", err_cnt, 0);
    chk("wrap_locked", locked, 1);

    // single glitch 3,9,5,6
    tick(4'd9, 1, 0);
    chk("gl_err0", err, 0);
    tick(4'd5, 1, 0);
    chk("gl_err1", err, 1);
    chk("gl_cnt1", err_cnt, 1);
    chk_cap("gl_cap1", 4'd4, 4'd9);
    tick(4'd6, 1, 0);
    chk("gl_err2", err, 1);
    chk("gl_cnt2", err_cnt, 2);
    chk_cap("gl_cap2", 4'd4, 4'd9);
    tick(4'd7, 1, 0);
    chk("gl_err3", err, 0);
    chk("gl_locked", locked, 1);

    // hold 7 for five cycles in total -> four errors, lock lost
    tick(4'd7, 1, 0);
    chk("hold_err0", err, 0);
    tick(4'd7, 1, 0);
    tick(4'd7, 1, 0);
    tick(4'd7, 1, 0);
    chk("hold_err3", err, 1);
    chk("hold_cnt3", err_cnt, 5);
    chk("hold_locked3", locked, 1);
    tick(4'd8, 1, 0);
    chk("loss_err", err, 1);
    chk("loss_cnt", err_cnt, 6);
    chk("loss_locked", locked, 0);

    // relock, with one mismatch in SEARCH that must not count
    tick(4'd12, 1, 0);
    tick(4'd13, 1, 0);
    chk("search_err", err, 0);
    chk("search_cnt", err_cnt, 6);
    s = 4'd14;
    for (int k = 32; k <= 39; k++) begin
      tick(s, 1, 0);
      s = s + 4'd1;
      if (k == 38) chk("relock_early", locked, 0);
    end
    chk("relock_on", locked, 1);
    chk("relock_cnt", err_cnt, 6);

    // clr alone, then clr coinciding with an error
    tick(4'd6, 1, 1);
    chk("clr_cnt", err_cnt, 0);
    chk_cap("clr_cap", 4'd0, 4'd0);
    tick(4'd7, 1, 0);
    tick(4'd14, 1, 0);
    tick(4'd9, 1, 1);
    chk("clr_err_err", err, 1);
    chk("clr_err_cnt", err_cnt, 1);
    chk_cap("clr_err_cap", 4'd8, 4'd14);
    tick(4'd10, 1, 0);
    chk("clr_err_cnt2", err_cnt, 2);
    chk_cap("clr_err_cap2", 4'd8, 4'd14);
    tick(4'd11, 1, 0);
    chk("clr_err_end", err, 0);

    // saturation: two errors per glitch
    s = 4'd12;
    for (int g = 0; g < 8; g++) begin
      tick(s + 4'd7, 1, 0);
      tick(s + 4'd1, 1, 0);
      tick(s + 4'd2, 1, 0);
      tick(s + 4'd3, 1, 0);
      s = s + 4'd4;
      chk("sat_cnt", err_cnt, (2 + 2 * (g + 1) > 15) ? 15 : 2 + 2 * (g + 1));
    end
    chk("sat_locked", locked, 1);
    chk_cap("sat_cap", 4'd8, 4'd14);

    // disable while locked
    tick(s, 0, 0);
    chk("dis_locked", locked, 0);
    chk("dis_cnt", err_cnt, 15);
    tick(4'd3, 0, 0);
    chk("dis_err", err, 0);
    chk("dis_cnt2", err_cnt, 15);
    chk_cap("dis_cap", 4'd8, 4'd14);
    tick(4'd3, 0, 1);
    chk("dis_clr", err_cnt, 0);

    // re-enable, relock, make an error, then async reset mid-cycle
    s = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      tick(s, 1, 0);
      s = s + 4'd1;
      if (k == 9) chk("re_early", locked, 0);
    end
    chk("re_locked", locked, 1);
    tick(s + 4'd7, 1, 0);
    tick(s + 4'd1, 1, 0);
    chk("pre_rst_cnt", err_cnt, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err", err, 0);
    chk("arst_cnt", err_cnt, 0);
    chk_cap("arst_cap", 4'd0, 4'd0);
    #10 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
